// File: rtl/packet_pkg.sv
// rtl/packet_pkg.sv - shared state encoding and stream defaults for the packet path
package packet_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PASS = 1'b1
    } state_t;

    // Defaults shared with packet_parser so both ends agree on word and counter sizing
    localparam int PACKET_WIDTH_DEF = 32;
    localparam int MAX_COUNT_DEF    = 15;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick starting just after the last grant
module rr_pick
    import packet_pkg::*;
#(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic         found,
    output logic [W-1:0] winner
);

    logic [N-1:0] rot;
    logic [W-1:0] start;
    logic [W-1:0] idx;
    logic [W-1:0] off;
    int           sum;

    always_comb begin
        start = (int'(last) == N - 1) ? '0 : last + W'(1);
        rot   = '0;
        idx   = '0;
        // Rotate so that bit 0 is the highest-priority requester this round
        for (int k = 0; k < N; k++) begin
            idx    = W'((int'(start) + k) % N);
            rot[k] = req[idx];
        end
        found = |rot;
        off   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) off = W'(k);
        end
        sum    = int'(start) + int'(off);
        winner = (sum >= N) ? W'(sum - N) : W'(sum);
    end

endmodule

// File: rtl/packet_arbiter.sv
// rtl/packet_arbiter.sv - round-robin packet arbiter feeding packet_parser, with idle watchdog
module packet_arbiter
    import packet_pkg::*;
#(
    parameter int PACKET_WIDTH = PACKET_WIDTH_DEF,
    parameter int NUM_SOURCES  = 4,
    parameter int IDLE_TIMEOUT = 15,
    parameter int MAX_COUNT    = MAX_COUNT_DEF,
    parameter int GW           = $clog2(NUM_SOURCES),
    parameter int CW           = $clog2(MAX_COUNT)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_SOURCES-1:0]           src_valid,
    input  logic [NUM_SOURCES*PACKET_WIDTH-1:0] src_data,
    input  logic [NUM_SOURCES-1:0]           src_sop,
    input  logic [NUM_SOURCES-1:0]           src_eop,
    output logic [NUM_SOURCES-1:0]           src_ready,
    output logic                             data_valid,
    output logic [PACKET_WIDTH-1:0]          packet_data_out,
    output logic                             start_of_packet,
    output logic                             end_of_packet,
    output logic [GW-1:0]                    grant_id,
    output logic                             busy,
    output logic                             abort_flag,
    output logic [CW-1:0]                    abort_counter,
    output logic [CW-1:0]                    drop_counter
);

    state_t                  state;
    logic [7:0]              idle_cnt;
    logic [NUM_SOURCES-1:0]  req;
    logic [NUM_SOURCES-1:0]  stray;
    logic [NUM_SOURCES-1:0]  ready_c;
    logic                    found;
    logic [GW-1:0]           winner;
    logic [GW-1:0]           sel;
    logic                    take;
    logic [PACKET_WIDTH-1:0] sel_data;
    logic                    sel_sop;
    logic                    sel_eop;

    assign req   = src_valid & src_sop;
    assign stray = src_valid & ~src_sop;

    rr_pick #(.N(NUM_SOURCES), .W(GW)) u_pick (
        .req    (req),
        .last   (grant_id),
        .found  (found),
        .winner (winner)
    );

    // In IDLE every non-SOP word is drained so a stalled source cannot block the next grant
    always_comb begin
        ready_c = '0;
        sel     = grant_id;
        take    = 1'b0;
        if (state == PASS) begin
            ready_c[grant_id] = 1'b1;
            take              = src_valid[grant_id];
        end else begin
            ready_c = stray;
            if (found) begin
                ready_c[winner] = 1'b1;
                sel             = winner;
                take            = 1'b1;
            end
        end
    end

    assign src_ready = ready_c;
    assign sel_data  = src_data[int'(sel)*PACKET_WIDTH +: PACKET_WIDTH];
    assign sel_sop   = src_sop[sel];
    assign sel_eop   = src_eop[sel];
    assign busy      = (state == PASS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            grant_id        <= GW'(NUM_SOURCES - 1);
            idle_cnt        <= '0;
            data_valid      <= 1'b0;
            packet_data_out <= '0;
            start_of_packet <= 1'b0;
            end_of_packet   <= 1'b0;
            abort_flag      <= 1'b0;
            abort_counter   <= '0;
            drop_counter    <= '0;
        end else begin
            data_valid      <= take;
            packet_data_out <= take ? sel_data : '0;
            start_of_packet <= take & sel_sop;
            end_of_packet   <= take & sel_eop;
            abort_flag      <= 1'b0;
            if (state == IDLE) begin
                idle_cnt <= '0;
                if (found) begin
                    grant_id <= winner;
                    state    <= src_eop[winner] ? IDLE : PASS;
                end
                if (|stray && drop_counter != CW'(MAX_COUNT))
                    drop_counter <= drop_counter + CW'(1);
            end else if (take) begin
                idle_cnt <= '0;
                if (sel_eop) state <= IDLE;
            end else if (idle_cnt == 8'(IDLE_TIMEOUT - 1)) begin
                // A word arriving on the timeout cycle takes the branch above instead
                state      <= IDLE;
                idle_cnt   <= '0;
                abort_flag <= 1'b1;
                if (abort_counter != CW'(MAX_COUNT))
                    abort_counter <= abort_counter + CW'(1);
            end else begin
                idle_cnt <= idle_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_packet_arbiter.sv
// tb/tb_packet_arbiter.sv - randomized and directed bench for packet_arbiter
module tb_packet_arbiter;
    import packet_pkg::*;

    localparam int NS = 4;
    localparam int PW = 32;
    localparam int TO = 15;
    localparam int MAXC = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NS-1:0]    src_valid, src_sop, src_eop, src_ready;
    logic [NS*PW-1:0] src_data;
    logic             data_valid, start_of_packet, end_of_packet, busy, abort_flag;
    logic [PW-1:0]    packet_data_out;
    logic [1:0]       grant_id;
    logic [3:0]       abort_counter, drop_counter;

    always #5 clk = ~clk;

    packet_arbiter #(.PACKET_WIDTH(PW), .NUM_SOURCES(NS), .IDLE_TIMEOUT(TO), .MAX_COUNT(MAXC)) dut (
        .clk(clk), .rst(rst), .src_valid(src_valid), .src_data(src_data), .src_sop(src_sop),
        .src_eop(src_eop), .src_ready(src_ready), .data_valid(data_valid),
        .packet_data_out(packet_data_out), .start_of_packet(start_of_packet),
        .end_of_packet(end_of_packet), .grant_id(grant_id), .busy(busy), .abort_flag(abort_flag),
        .abort_counter(abort_counter), .drop_counter(drop_counter)
    );

    typedef struct packed {
        logic [PW-1:0] data;
        logic          sop;
        logic          eop;
    } word_t;

    word_t srcq[NS][$];
    int    stall[NS];
    bit    rnd = 1'b0;
    int    n_pass = 0, n_total = 0, cyc = 0;

    bit            m_busy;
    int            m_grant, m_idle, m_drop, m_abort;
    logic          e_valid, e_sop, e_eop, e_abort;
    logic [PW-1:0] e_data;

    int sop_log[$], out_cyc[$], abort_cyc[$], abort_busy[$];
    int sop_acc_cyc[NS], eop_acc_cyc[NS];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    endtask

    task automatic clear_logs();
        sop_log.delete(); out_cyc.delete(); abort_cyc.delete(); abort_busy.delete();
        for (int i = 0; i < NS; i++) begin
            sop_acc_cyc[i] = -100;
            eop_acc_cyc[i] = -100;
        end
    endtask

    task automatic add_pkt(int s, int len, bit close);
        for (int k = 0; k < len; k++) begin
            word_t w;
            w.data = $urandom;
            w.sop  = (k == 0);
            w.eop  = close && (k == len - 1);
            srcq[s].push_back(w);
        end
    endtask

    task automatic add_stray(int s, int n);
        for (int k = 0; k < n; k++) begin
            word_t w;
            w.data = $urandom;
            w.sop  = 1'b0;
            w.eop  = 1'($urandom_range(0, 1));
            srcq[s].push_back(w);
        end
    endtask

    function automatic bit any_pending();
        bit p = 1'b0;
        for (int i = 0; i < NS; i++) if (srcq[i].size() > 0) p = 1'b1;
        return p;
    endfunction

    // Which sources the spec says must see ready this cycle
    function automatic logic [NS-1:0] model_ready();
        logic [NS-1:0] r;
        int c;
        r = '0;
        if (m_busy) begin
            r[m_grant] = 1'b1;
        end else begin
            r = src_valid & ~src_sop;
            for (int k = 1; k <= NS; k++) begin
                c = (m_grant + k) % NS;
                if (src_valid[c] && src_sop[c]) begin
                    r[c] = 1'b1;
                    break;
                end
            end
        end
        return r;
    endfunction

    task automatic model_step();
        int w;
        e_valid = 0; e_sop = 0; e_eop = 0; e_data = '0; e_abort = 0;
        if (!m_busy) begin
            w = -1;
            for (int k = 1; k <= NS; k++) begin
                if (w < 0 && src_valid[(m_grant + k) % NS] && src_sop[(m_grant + k) % NS])
                    w = (m_grant + k) % NS;
            end
            if (w >= 0) begin
                e_valid = 1; e_data = src_data[w*PW +: PW]; e_sop = src_sop[w]; e_eop = src_eop[w];
                m_grant = w;
                m_busy  = !src_eop[w];
                m_idle  = 0;
            end
            if ((src_valid & ~src_sop) != 0 && m_drop < MAXC) m_drop++;
        end else if (src_valid[m_grant]) begin
            e_valid = 1; e_data = src_data[m_grant*PW +: PW];
            e_sop = src_sop[m_grant]; e_eop = src_eop[m_grant];
            m_idle = 0;
            if (src_eop[m_grant]) m_busy = 0;
        end else begin
            m_idle++;
            if (m_idle == TO) begin
                m_busy = 0; m_idle = 0; e_abort = 1;
                if (m_abort < MAXC) m_abort++;
            end
        end
    endtask

    task automatic drive();
        bit go;
        for (int i = 0; i < NS; i++) begin
            go = srcq[i].size() > 0;
            if (rnd) begin
                if (stall[i] > 0) begin
                    stall[i]--;
                    go = 0;
                end else if ($urandom_range(0, 39) == 0) begin
                    stall[i] = $urandom_range(13, 20);
                    go = 0;
                end else if ($urandom_range(0, 9) < 3) begin
                    go = 0;
                end
            end
            if (go) begin
                src_valid[i] = 1'b1;
                src_sop[i]   = srcq[i][0].sop;
                src_eop[i]   = srcq[i][0].eop;
                src_data[i*PW +: PW] = srcq[i][0].data;
            end else begin
                src_valid[i] = 1'b0;
                src_sop[i]   = 1'($urandom_range(0, 1));
                src_eop[i]   = 1'($urandom_range(0, 1));
                src_data[i*PW +: PW] = $urandom;
            end
        end
    endtask

    task automatic finish_cycle();
        logic [NS-1:0] r, acc;
        word_t w;
        #1;
        r = model_ready();
        chk("src_ready", 64'(src_ready), 64'(r));
        acc = r & src_valid;
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NS; i++) begin
            if (acc[i] && srcq[i].size() > 0) begin
                w = srcq[i].pop_front();
                if (w.sop) sop_acc_cyc[i] = cyc;
                if (w.eop) eop_acc_cyc[i] = cyc;
            end
        end
        chk("data_valid", 64'(data_valid), 64'(e_valid));
        chk("start_of_packet", 64'(start_of_packet), 64'(e_sop));
        chk("end_of_packet", 64'(end_of_packet), 64'(e_eop));
        if (e_valid) chk("packet_data_out", 64'(packet_data_out), 64'(e_data));
        chk("grant_id", 64'(grant_id), 64'(m_grant));
        chk("busy", 64'(busy), 64'(m_busy));
        chk("abort_flag", 64'(abort_flag), 64'(e_abort));
        chk("abort_counter", 64'(abort_counter), 64'(m_abort));
        chk("drop_counter", 64'(drop_counter), 64'(m_drop));
        if (data_valid) out_cyc.push_back(cyc);
        if (data_valid && start_of_packet) sop_log.push_back(int'(grant_id));
        if (abort_flag) begin
            abort_cyc.push_back(cyc);
            abort_busy.push_back(int'(busy));
        end
    endtask

    task automatic cycle();
        drive();
        finish_cycle();
    endtask

    task automatic run_drain(int limit);
        int n = 0;
        while ((any_pending() || m_busy) && n < limit) begin
            cycle();
            n++;
        end
        chk("drain_bound", 64'(n < limit), 64'(1));
        cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        src_valid = '0; src_sop = '0; src_eop = '0; src_data = '0;
        for (int i = 0; i < NS; i++) begin
            srcq[i].delete();
            stall[i] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        m_busy = 0; m_grant = NS - 1; m_idle = 0; m_drop = 0; m_abort = 0;
        e_valid = 0; e_sop = 0; e_eop = 0; e_data = '0; e_abort = 0;
        clear_logs();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        do_reset();
        chk("rst_data_valid", 64'(data_valid), 64'(0));
        chk("rst_packet_data_out", 64'(packet_data_out), 64'(0));
        chk("rst_grant_id", 64'(grant_id), 64'(3));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_abort_counter", 64'(abort_counter), 64'(0));
        chk("rst_drop_counter", 64'(drop_counter), 64'(0));

        // Fairness: two rounds of 5-word packets from every source
        for (int p = 0; p < 2; p++)
            for (int s = 0; s < NS; s++) add_pkt(s, 5, 1'b1);
        run_drain(200);
        chk("fair_sop_count", 64'(sop_log.size()), 64'(8));
        if (sop_log.size() >= 8)
            for (int k = 0; k < 8; k++) chk("fair_grant_order", 64'(sop_log[k]), 64'(k % 4));
        chk("fair_word_count", 64'(out_cyc.size()), 64'(40));
        if (out_cyc.size() >= 40) chk("fair_contiguous", 64'(out_cyc[39] - out_cyc[0]), 64'(39));

        // No interleaving: source 2 raises SOP while source 1 sends word 3
        clear_logs();
        add_pkt(1, 5, 1'b1);
        cycle();
        cycle();
        add_pkt(2, 4, 1'b1);
        run_drain(100);
        chk("noint_handoff", 64'(sop_acc_cyc[2] - eop_acc_cyc[1]), 64'(1));
        if (out_cyc.size() >= 9) chk("noint_contiguous", 64'(out_cyc[8] - out_cyc[0]), 64'(8));

        // Single-word packet from source 3, then 0 and 2 compete
        clear_logs();
        add_pkt(3, 1, 1'b1);
        cycle();
        chk("single_valid", 64'(data_valid), 64'(1));
        chk("single_sop", 64'(start_of_packet), 64'(1));
        chk("single_eop", 64'(end_of_packet), 64'(1));
        chk("single_busy", 64'(busy), 64'(0));
        chk("single_grant", 64'(grant_id), 64'(3));
        add_pkt(0, 3, 1'b1);
        add_pkt(2, 3, 1'b1);
        run_drain(100);
        if (sop_log.size() >= 3) begin
            chk("single_next_grant", 64'(sop_log[1]), 64'(0));
            chk("single_then_grant", 64'(sop_log[2]), 64'(2));
        end

        // Watchdog: source 0 stalls after 3 words, source 1 waits
        do_reset();
        add_pkt(0, 3, 1'b0);
        add_pkt(1, 2, 1'b1);
        run_drain(100);
        chk("wd_abort_pulses", 64'(abort_cyc.size()), 64'(1));
        if (abort_cyc.size() >= 1 && out_cyc.size() >= 3) begin
            chk("wd_abort_delay", 64'(abort_cyc[0] - out_cyc[2]), 64'(15));
            chk("wd_busy_at_abort", 64'(abort_busy[0]), 64'(0));
        end
        chk("wd_abort_counter", 64'(abort_counter), 64'(1));
        if (sop_log.size() >= 2) chk("wd_next_grant", 64'(sop_log[1]), 64'(1));

        // Saturation: 20 stray words in IDLE
        do_reset();
        add_stray(2, 20);
        run_drain(100);
        chk("sat_drop_counter", 64'(drop_counter), 64'(15));
        chk("sat_no_output", 64'(out_cyc.size()), 64'(0));

        // Reset during word 2 of a packet from source 2
        do_reset();
        add_pkt(2, 5, 1'b1);
        cycle();
        drive();
        #2;
        rst = 1'b1;
        #1;
        chk("rstmid_data_valid", 64'(data_valid), 64'(0));
        chk("rstmid_sop", 64'(start_of_packet), 64'(0));
        chk("rstmid_data", 64'(packet_data_out), 64'(0));
        chk("rstmid_busy", 64'(busy), 64'(0));
        chk("rstmid_grant", 64'(grant_id), 64'(3));
        do_reset();
        add_pkt(1, 2, 1'b1);
        add_pkt(0, 2, 1'b1);
        run_drain(100);
        if (sop_log.size() >= 1) chk("rstmid_first_grant", 64'(sop_log[0]), 64'(0));

        // Randomized traffic with stalls, unterminated packets and stray words
        do_reset();
        rnd = 1'b1;
        for (int r = 0; r < 1500; r++) begin
            for (int s = 0; s < NS; s++)
                if (srcq[s].size() < 3 && $urandom_range(0, 7) == 0)
                    add_pkt(s, $urandom_range(1, 6), $urandom_range(0, 15) != 0);
            if ($urandom_range(0, 30) == 0) add_stray($urandom_range(0, NS - 1), $urandom_range(1, 3));
            cycle();
        end
        rnd = 1'b0;
        run_drain(600);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
